fifo_ctrl: RTL and testbench
============================

Name: fifo_ctrl

Overview:
- Control sequencer for the 8-entry FIFO register file.
- Decides each cycle whether to write, read, or idle.
- Owns the head/tail pointers and the occupancy count, and flags full, empty, ack and error conditions.
- Drives the register file's write strobe/address (into the 3-to-8 write decode path) and the read-select address (into the read mux); data itself never passes through this block.

Parameters:
ADDR_W, 3, pointer/address width; FIFO depth = 2**ADDR_W (8)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write request from producer
rd_en  input  1  read request from consumer
we  output  1  register-file write enable (gates decoded write address)
wAddr  output  ADDR_W  register-file write address (tail)
re  output  1  read strobe; output data register loads when high
rAddr  output  ADDR_W  register-file read address (head)
data_count  output  ADDR_W+1  current occupancy, 0..8
full  output  1  data_count == 8
empty  output  1  data_count == 0
wr_ack  output  1  write accepted
wr_err  output  1  write refused (FIFO full)
rd_ack  output  1  read accepted
rd_err  output  1  read refused (FIFO empty)

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=INIT; head=tail=0; data_count=0.
  - we=re=wr_ack=wr_err=rd_ack=rd_err=0; wAddr=rAddr=0.
  - empty=1, full=0.
- States: INIT, NO_OP, WRITE, WR_ERROR, READ, RD_ERROR. The state register is the only state besides head, tail and data_count.
- Next-state decision, evaluated at each rising edge from inputs and current data_count:
  - wr_en=1, rd_en=0: WRITE if !full, else WR_ERROR.
  - rd_en=1, wr_en=0: READ if !empty, else RD_ERROR.
  - wr_en=1, rd_en=1: one op per cycle, write has priority. WRITE if !full, else READ (full implies not empty). No error flag in this case.
  - Neither asserted: NO_OP.
  - INIT is left on the first edge after reset release using the same rules.
- Edge that enters WRITE: tail<=tail+1 (mod 8, 7->0 wraps), data_count<=data_count+1.
- Edge that enters READ: head<=head+1 (mod 8), data_count<=data_count-1.
- All other transitions leave head, tail and data_count unchanged.
- Outputs are registered (Moore on state), valid for the cycle after the deciding edge, i.e. latency 1:
  - WRITE: we=1, wr_ack=1, wAddr=pre-increment tail. The register file captures din at the next edge.
  - READ: re=1, rd_ack=1, rAddr=pre-increment head.
  - WR_ERROR: wr_err=1, everything else 0.
  - RD_ERROR: rd_err=1, everything else 0.
  - NO_OP and INIT: all strobes 0; wAddr/rAddr hold their last values.
- full and empty decode combinationally from the registered data_count, so they reflect the post-operation count in the same cycle as the ack.
- Strobe exclusivity: at most one of we/re is high per cycle. ack and err for the same direction are never both high.
- Invariants:
  - data_count never exceeds 8 and never underflows.
  - data_count == (tail - head) mod 8, except data_count == 8 when tail == head with full.
- Reset mid-operation: an asserted we/re drops immediately (asynchronously); the in-flight write is lost and the FIFO is empty.
- Sustained requests: back-to-back WRITE/READ every cycle are supported, with no bubble.

Test Plan:
1. Reset, then 8 consecutive wr_en cycles -> wAddr 0..7 with we=wr_ack=1 each cycle; data_count 1..8; full=1 in the 8th ack cycle; empty drops in the 1st.
2. From full, one more wr_en -> wr_err=1, we=0, data_count stays 8, tail stays 0.
3. From full, 8 rd_en cycles -> rAddr 0..7, re=rd_ack=1, data_count 7..0, empty=1 in the last; a 9th rd_en -> rd_err=1, re=0.
4. Wrap-around: write 5, read 5, then write 6 -> wAddr 5,6,7,0,1,2, data_count=6, full=0.
5. Simultaneous wr_en=rd_en=1: with count 3 -> WRITE, count 4. With count 8 -> READ, count 7, rAddr=head. No wr_err or rd_err asserted in either case.
6. Assert reset_n=0 mid-cycle while we=1 and count 5 -> we drops without waiting for clk, data_count=0, empty=1; the first post-reset write uses wAddr=0.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl
//   Control sequencer for an 8-entry FIFO register file. Each cycle it
//   decides whether to write, read or idle. It owns the head/tail pointers and
//   the occupancy count. It drives the register file's write strobe/address
//   and its read-select address. Data never passes through this block.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   wr_en      write request from producer
//   rd_en      read request from consumer
//   we         register-file write enable (gates the decoded write address)
//   wAddr      register-file write address (tail before increment)
//   re         read strobe; the output data register loads when high
//   rAddr      register-file read address (head before increment)
//   data_count current occupancy, 0..2**ADDR_W
//   full       data_count == 2**ADDR_W
//   empty      data_count == 0
//   wr_ack     write accepted
//   wr_err     write refused because the FIFO is full
//   rd_ack     read accepted
//   rd_err     read refused because the FIFO is empty
module fifo_ctrl #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic              re,
  output logic [ADDR_W-1:0] rAddr,
  output logic [ADDR_W:0]   data_count,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    INIT,
    NO_OP,
    WRITE,
    WR_ERROR,
    READ,
    RD_ERROR
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;

  // full/empty come from the registered count. They therefore show the
  // post-operation occupancy in the same cycle as the ack.
  assign full  = (data_count == DEPTH);
  assign empty = (data_count == '0);

  // The decision depends only on the requests and the current count. INIT
  // follows the same rules, so every state shares one decision tree.
  // Write wins when both requests are present. A simultaneous request against
  // a full FIFO turns into a read. That read is always legal because full
  // implies not empty, and it raises no error.
  always_comb begin
    next_state = state;
    if (wr_en && !full)
      next_state = WRITE;
    else if (wr_en && rd_en)
      next_state = READ;
    else if (wr_en)
      next_state = WR_ERROR;
    else if (rd_en && !empty)
      next_state = READ;
    else if (rd_en)
      next_state = RD_ERROR;
    else
      next_state = NO_OP;
  end

  // The state register and the Moore outputs are loaded together. The strobes
  // therefore come straight from flops, one cycle after the deciding edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      we         <= 1'b0;
      re         <= 1'b0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
      wAddr      <= '0;
      rAddr      <= '0;
    end else begin
      state  <= next_state;
      we     <= (next_state == WRITE);
      wr_ack <= (next_state == WRITE);
      re     <= (next_state == READ);
      rd_ack <= (next_state == READ);
      wr_err <= (next_state == WR_ERROR);
      rd_err <= (next_state == RD_ERROR);
      case (next_state)
        WRITE: begin
          wAddr      <= tail;
          tail       <= tail + 1'b1;
          data_count <= data_count + 1'b1;
        end
        READ: begin
          rAddr      <= head;
          head       <= head + 1'b1;
          data_count <= data_count - 1'b1;
        end
        // Idle and error cycles keep the pointers, the count and the last
        // addresses presented to the register file.
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl
//   Scoreboard bench for fifo_ctrl. The stimulus tasks drive wr_en/rd_en on
//   the falling edge. A reference model predicts the outputs of the next
//   rising edge, and the prediction is queued. A monitor pops each prediction
//   one time unit after the rising edge and compares it. Each scenario task
//   also checks its own boundary conditions inline against constants.
module tb_fifo_ctrl;

  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset_n;
  logic              wr_en;
  logic              rd_en;
  logic              we;
  logic [ADDR_W-1:0] wAddr;
  logic              re;
  logic [ADDR_W-1:0] rAddr;
  logic [ADDR_W:0]   data_count;
  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;

  fifo_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .we         (we),
    .wAddr      (wAddr),
    .re         (re),
    .rAddr      (rAddr),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err)
  );

  typedef struct packed {
    logic              we;
    logic              re;
    logic              wr_ack;
    logic              wr_err;
    logic              rd_ack;
    logic              rd_err;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   txn     = 0;

  // Reference model state
  int   m_count;
  int   m_head;
  int   m_tail;
  int   m_waddr;
  int   m_raddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, errors);
    $fatal(1);
  end

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      e = exp_q.pop_front();
      a = '{we, re, wr_ack, wr_err, rd_ack, rd_err, wAddr, rAddr, data_count, full, empty};
      vectors++;
      txn++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard txn %0d: got we=%b re=%b wack=%b werr=%b rack=%b rerr=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b, exp we=%b re=%b wack=%b werr=%b rack=%b rerr=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b",
                 txn, a.we, a.re, a.wr_ack, a.wr_err, a.rd_ack, a.rd_err, a.waddr, a.raddr, a.count, a.full, a.empty,
                 e.we, e.re, e.wr_ack, e.wr_err, e.rd_ack, e.rd_err, e.waddr, e.raddr, e.count, e.full, e.empty);
      end else begin
        $display("txn %0d: we=%b re=%b wack=%b werr=%b rack=%b rerr=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b ok",
                 txn, a.we, a.re, a.wr_ack, a.wr_err, a.rd_ack, a.rd_err, a.waddr, a.raddr, a.count, a.full, a.empty);
      end
    end
  end

  task automatic model_reset();
    m_count = 0;
    m_head  = 0;
    m_tail  = 0;
    m_waddr = 0;
    m_raddr = 0;
  endtask

  // Drive one request cycle and queue the predicted response.
  task automatic drive(input logic w, input logic r);
    obs_t e;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    e = '0;
    if (w && m_count < 8) begin
      e.we = 1'b1;
      e.wr_ack = 1'b1;
      m_waddr = m_tail;
      m_tail = (m_tail + 1) % 8;
      m_count++;
    end else if (w && r) begin
      e.re = 1'b1;
      e.rd_ack = 1'b1;
      m_raddr = m_head;
      m_head = (m_head + 1) % 8;
      m_count--;
    end else if (w) begin
      e.wr_err = 1'b1;
    end else if (r && m_count > 0) begin
      e.re = 1'b1;
      e.rd_ack = 1'b1;
      m_raddr = m_head;
      m_head = (m_head + 1) % 8;
      m_count--;
    end else if (r) begin
      e.rd_err = 1'b1;
    end
    e.waddr = m_waddr[ADDR_W-1:0];
    e.raddr = m_raddr[ADDR_W-1:0];
    e.count = m_count[ADDR_W:0];
    e.full  = (m_count == 8);
    e.empty = (m_count == 0);
    exp_q.push_back(e);
  endtask

  // Move to just after the edge that answers the last drive().
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({we, re, wr_ack, wr_err, rd_ack, rd_err} !== 6'b0 || wAddr !== 3'd0 || rAddr !== 3'd0 ||
        data_count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got strobes=%b wa=%0d ra=%0d cnt=%0d full=%b empty=%b, need 0/0/0/0/0/1",
               {we, re, wr_ack, wr_err, rd_ack, rd_err}, wAddr, rAddr, data_count, full, empty);
    end
    drive(1'b0, 1'b0);
    settle();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0);
      if (i == 0) begin
        settle();
        vectors++;
        if (empty !== 1'b0) begin
          errors++;
          $display("FAIL fill_empty_drop: empty=%b, need 0", empty);
        end
      end
    end
    settle();
    vectors++;
    if (full !== 1'b1 || wAddr !== 3'd7 || data_count !== 4'd8) begin
      errors++;
      $display("FAIL fill_full: full=%b wa=%0d cnt=%0d, need 1/7/8", full, wAddr, data_count);
    end
  endtask

  task automatic test_write_full();
    drive(1'b1, 1'b0);
    settle();
    vectors++;
    if (wr_err !== 1'b1 || we !== 1'b0 || wr_ack !== 1'b0 || data_count !== 4'd8) begin
      errors++;
      $display("FAIL write_when_full: werr=%b we=%b wack=%b cnt=%0d, need 1/0/0/8", wr_err, we, wr_ack, data_count);
    end
    // tail must still be 0, so the write after one read lands at 0.
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    settle();
    vectors++;
    if (wAddr !== 3'd0) begin
      errors++;
      $display("FAIL tail_held_on_err: wa=%0d, need 0", wAddr);
    end
  endtask

  task automatic test_drain();
    // Start from a full FIFO with head=1 (left by test_write_full).
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1);
    settle();
    vectors++;
    if (empty !== 1'b1 || data_count !== 4'd0 || rAddr !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b cnt=%0d ra=%0d, need 1/0/0", empty, data_count, rAddr);
    end
    drive(1'b0, 1'b1);
    settle();
    vectors++;
    if (rd_err !== 1'b1 || re !== 1'b0 || rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_when_empty: rerr=%b re=%b rack=%b, need 1/0/0", rd_err, re, rd_ack);
    end
  endtask

  task automatic test_read_order();
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1);
      settle();
      vectors++;
      if (rAddr !== i[ADDR_W-1:0] || data_count !== 4'(7 - i)) begin
        errors++;
        $display("FAIL read_order %0d: ra=%0d cnt=%0d, need %0d/%0d", i, rAddr, data_count, i, 7 - i);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0);
    settle();
    vectors++;
    if (wAddr !== 3'd2 || data_count !== 4'd6 || full !== 1'b0) begin
      errors++;
      $display("FAIL wrap: wa=%0d cnt=%0d full=%b, need 2/6/0", wAddr, data_count, full);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    settle();
    vectors++;
    if (we !== 1'b1 || re !== 1'b0 || data_count !== 4'd4 || wr_err !== 1'b0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_count3: we=%b re=%b cnt=%0d werr=%b rerr=%b, need 1/0/4/0/0", we, re, data_count, wr_err, rd_err);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
    settle();
    vectors++;
    if (re !== 1'b1 || we !== 1'b0 || data_count !== 4'd7 || rAddr !== 3'd0 || wr_err !== 1'b0 || rd_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: re=%b we=%b cnt=%0d ra=%0d werr=%b rerr=%b, need 1/0/7/0/0/0", re, we, data_count, rAddr, wr_err, rd_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    settle();
    // Now 2 time units past the edge: we=1 and count=5. The monitor has
    // already consumed the prediction for this edge.
    vectors++;
    if (we !== 1'b1 || data_count !== 4'd5) begin
      errors++;
      $display("FAIL async_pre: we=%b cnt=%0d, need 1/5", we, data_count);
    end
    #1;
    reset_n = 1'b0;
    wr_en = 1'b0;
    #1;
    vectors++;
    if (we !== 1'b0 || data_count !== 4'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: we=%b cnt=%0d empty=%b, need 0/0/1", we, data_count, empty);
    end
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b0);
    settle();
    vectors++;
    if (wAddr !== 3'd0 || we !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_write: wa=%0d we=%b, need 0/1", wAddr, we);
    end
  endtask

  task automatic test_back_to_back();
    // Random request mix. The scoreboard checks every cycle.
    for (int i = 0; i < 60; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(1'b0, 1'b0);
    settle();
  endtask

  initial begin
    reset_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    model_reset();
    test_reset();
    test_fill();
    test_write_full();
    test_drain();
    test_read_order();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d predictions left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
